// File: rtl/data_port_pkg.sv
// Shared constants and types for the data-side memory port.
package data_port_pkg;

    typedef enum logic [1:0] {
        DP_IDLE  = 2'd0,
        DP_WRITE = 2'd1,
        DP_READ  = 2'd2
    } dp_state_t;

    localparam logic [3:0]  STRB_WORD = 4'b1111;
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/data_port_if.sv
// Pipeline-side and bus-side signal bundles for the data port.
interface data_port_pipe_if;
    logic        MEM_WAIT;
    logic        ERR;
    logic        DATA_RDEN;
    logic [31:0] DATA_RIADDR;
    logic        DATA_RVALID;
    logic [31:0] DATA_ROADDR;
    logic [31:0] DATA_RDATA;
    logic        DATA_WREN;
    logic [31:0] DATA_WADDR;
    logic [3:0]  DATA_WSTRB;
    logic [31:0] DATA_WDATA;

    // pipeline side issues requests
    modport master (
        output DATA_RDEN, DATA_RIADDR, DATA_WREN, DATA_WADDR, DATA_WSTRB, DATA_WDATA,
        input  MEM_WAIT, ERR, DATA_RVALID, DATA_ROADDR, DATA_RDATA
    );

    // data port serves them
    modport slave (
        input  DATA_RDEN, DATA_RIADDR, DATA_WREN, DATA_WADDR, DATA_WSTRB, DATA_WDATA,
        output MEM_WAIT, ERR, DATA_RVALID, DATA_ROADDR, DATA_RDATA
    );
endinterface

interface data_port_bus_if;
    logic        BUS_REQ;
    logic        BUS_WE;
    logic [31:0] BUS_ADDR;
    logic [3:0]  BUS_STRB;
    logic [31:0] BUS_WDATA;
    logic        BUS_ACK;
    logic [31:0] BUS_RDATA;

    // data port drives the memory bus
    modport master (
        output BUS_REQ, BUS_WE, BUS_ADDR, BUS_STRB, BUS_WDATA,
        input  BUS_ACK, BUS_RDATA
    );

    // memory / MMU answers
    modport slave (
        input  BUS_REQ, BUS_WE, BUS_ADDR, BUS_STRB, BUS_WDATA,
        output BUS_ACK, BUS_RDATA
    );
endinterface

// File: rtl/dp_timeout.sv
// Bus-wait watchdog: counts stalled cycles and flags the one that reaches TIMEOUT.
module dp_timeout #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] count;

    // cycle counter; clear has priority over counting
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + TO_W'(1);
        end
    end

    // this waiting cycle is the TIMEOUT-th one without acknowledge
    assign expire = en && (count == LAST);

endmodule

// File: rtl/data_port.sv
// Data-side memory responder: serialises pipeline reads/writes onto a
// single request/acknowledge bus and stalls the pipeline meanwhile.
module data_port
    import data_port_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input logic             CLK,
    input logic             RST,
    data_port_pipe_if.slave pipe,
    data_port_bus_if.master bus
);

    dp_state_t   state, state_next;

    logic        pend, pend_d;
    logic [31:0] pend_addr, pend_addr_d;
    logic [31:0] rd_addr, rd_addr_d;

    logic        mem_wait_d, err_d, rvalid_d;
    logic [31:0] roaddr_d, rdata_d;
    logic        req_d, we_d;
    logic [31:0] addr_d, wdata_d;
    logic [3:0]  strb_d;

    logic        busy, expire, done, to_clr, to_en;

    assign busy   = (state != DP_IDLE);
    assign to_en  = busy && !bus.BUS_ACK;
    assign done   = busy && (bus.BUS_ACK || expire);
    // idle or finishing: next op always starts from a zero count
    assign to_clr = !busy || done;

    dp_timeout #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout (
        .clk    (CLK),
        .rst    (RST),
        .clr    (to_clr),
        .en     (to_en),
        .expire (expire)
    );

    // state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= DP_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state: write goes first when both arrive; a pending read follows it
    always_comb begin
        state_next = state;
        case (state)
            DP_IDLE: begin
                if (pipe.DATA_WREN) begin
                    state_next = DP_WRITE;
                end else if (pipe.DATA_RDEN) begin
                    state_next = DP_READ;
                end
            end
            DP_WRITE: begin
                if (done) begin
                    state_next = pend ? DP_READ : DP_IDLE;
                end
            end
            DP_READ: begin
                if (done) begin
                    state_next = DP_IDLE;
                end
            end
            default: state_next = DP_IDLE;
        endcase
    end

    // output decode: computes next values of every registered output; holds by default
    always_comb begin
        mem_wait_d  = pipe.MEM_WAIT;
        err_d       = 1'b0;
        rvalid_d    = 1'b0;
        roaddr_d    = pipe.DATA_ROADDR;
        rdata_d     = pipe.DATA_RDATA;
        req_d       = bus.BUS_REQ;
        we_d        = bus.BUS_WE;
        addr_d      = bus.BUS_ADDR;
        strb_d      = bus.BUS_STRB;
        wdata_d     = bus.BUS_WDATA;
        pend_d      = pend;
        pend_addr_d = pend_addr;
        rd_addr_d   = rd_addr;
        case (state)
            DP_IDLE: begin
                if (pipe.DATA_WREN) begin
                    req_d       = 1'b1;
                    we_d        = 1'b1;
                    addr_d      = word_align(pipe.DATA_WADDR);
                    strb_d      = pipe.DATA_WSTRB;
                    wdata_d     = pipe.DATA_WDATA;
                    mem_wait_d  = 1'b1;
                    pend_d      = pipe.DATA_RDEN;
                    pend_addr_d = pipe.DATA_RIADDR;
                end else if (pipe.DATA_RDEN) begin
                    req_d      = 1'b1;
                    we_d       = 1'b0;
                    addr_d     = word_align(pipe.DATA_RIADDR);
                    strb_d     = STRB_WORD;
                    rd_addr_d  = pipe.DATA_RIADDR;
                    mem_wait_d = 1'b1;
                end
            end
            DP_WRITE: begin
                if (done) begin
                    err_d = !bus.BUS_ACK;
                    if (pend) begin
                        // REQ stays high: the pending read is loaded straight onto the bus
                        we_d      = 1'b0;
                        addr_d    = word_align(pend_addr);
                        strb_d    = STRB_WORD;
                        rd_addr_d = pend_addr;
                        pend_d    = 1'b0;
                    end else begin
                        req_d      = 1'b0;
                        mem_wait_d = 1'b0;
                    end
                end
            end
            DP_READ: begin
                if (done) begin
                    err_d      = !bus.BUS_ACK;
                    rvalid_d   = 1'b1;
                    roaddr_d   = rd_addr;
                    rdata_d    = bus.BUS_ACK ? bus.BUS_RDATA : '0;
                    req_d      = 1'b0;
                    mem_wait_d = 1'b0;
                end
            end
            default: begin
                req_d      = 1'b0;
                mem_wait_d = 1'b0;
            end
        endcase
    end

    // output and bookkeeping registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            pipe.MEM_WAIT    <= 1'b0;
            pipe.ERR         <= 1'b0;
            pipe.DATA_RVALID <= 1'b0;
            pipe.DATA_ROADDR <= '0;
            pipe.DATA_RDATA  <= '0;
            bus.BUS_REQ      <= 1'b0;
            bus.BUS_WE       <= 1'b0;
            bus.BUS_ADDR     <= '0;
            bus.BUS_STRB     <= '0;
            bus.BUS_WDATA    <= '0;
            pend             <= 1'b0;
            pend_addr        <= '0;
            rd_addr          <= '0;
        end else begin
            pipe.MEM_WAIT    <= mem_wait_d;
            pipe.ERR         <= err_d;
            pipe.DATA_RVALID <= rvalid_d;
            pipe.DATA_ROADDR <= roaddr_d;
            pipe.DATA_RDATA  <= rdata_d;
            bus.BUS_REQ      <= req_d;
            bus.BUS_WE       <= we_d;
            bus.BUS_ADDR     <= addr_d;
            bus.BUS_STRB     <= strb_d;
            bus.BUS_WDATA    <= wdata_d;
            pend             <= pend_d;
            pend_addr        <= pend_addr_d;
            rd_addr          <= rd_addr_d;
        end
    end

endmodule

// File: tb/tb_data_port.sv
// Randomised scoreboard bench for data_port with a reactive memory model.
module tb_data_port;

    localparam int unsigned T     = 4;
    localparam int unsigned NEVER = 1000;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    data_port_pipe_if pipe();
    data_port_bus_if  bus();

    data_port #(.TIMEOUT(T), .TO_W(3)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .pipe (pipe),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } rd_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } bus_exp_t;

    rd_exp_t     rd_q[$];
    bus_exp_t    bus_q[$];
    int unsigned lat_q[$];

    logic [31:0] mmem [int unsigned];
    logic [31:0] smem [int unsigned];

    int          n_vec = 0;
    int          n_bad = 0;
    int          err_exp = 0, err_seen = 0;
    int          rv_exp = 0, rv_seen = 0;
    logic [31:0] hold_addr = '0, hold_data = '0;
    logic        stale_ack = 1'b0;

    function automatic logic [31:0] init_word(input int unsigned w);
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] mread(input int unsigned w);
        if (mmem.exists(w)) return mmem[w];
        return init_word(w);
    endfunction

    function automatic logic [31:0] sread(input int unsigned w);
        if (smem.exists(w)) return smem[w];
        return init_word(w);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic report();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    endtask

    // Monitor: pops the read scoreboard on every RVALID, otherwise checks hold
    initial begin
        rd_exp_t e;
        forever begin
            @(negedge CLK);
            if (RST !== 1'b0) continue;
            if (pipe.ERR) err_seen++;
            if (pipe.DATA_RVALID) begin
                rv_seen++;
                if (rd_q.size() == 0) begin
                    chk("unexpected_rvalid", pipe.DATA_RVALID, 32'd0);
                end else begin
                    e = rd_q.pop_front();
                    chk("roaddr", pipe.DATA_ROADDR, e.addr);
                    chk("rdata", pipe.DATA_RDATA, e.data);
                    chk("read_err", pipe.ERR, e.err);
                    hold_addr = e.addr;
                    hold_data = e.data;
                end
            end else begin
                chk("hold_roaddr", pipe.DATA_ROADDR, hold_addr);
                chk("hold_rdata", pipe.DATA_RDATA, hold_data);
            end
        end
    end

    // Memory model: answers each bus transaction after its scheduled latency
    initial begin
        bit          active;
        int unsigned lat, cnt, w;
        bus_exp_t    cur;
        active = 1'b0;
        lat = 0;
        cnt = 0;
        bus.BUS_ACK   = 1'b0;
        bus.BUS_RDATA = '0;
        forever begin
            @(negedge CLK);
            bus.BUS_ACK   = 1'b0;
            bus.BUS_RDATA = $urandom;
            if (RST) begin
                active = 1'b0;
                continue;
            end
            if (stale_ack) begin
                stale_ack   = 1'b0;
                bus.BUS_ACK = 1'b1;
                continue;
            end
            if (bus.BUS_REQ && !active) begin
                if (bus_q.size() == 0 || lat_q.size() == 0) begin
                    chk("unexpected_bus_req", bus.BUS_REQ, 32'd0);
                    lat = 1;
                    cur = '{we: bus.BUS_WE, addr: bus.BUS_ADDR, strb: bus.BUS_STRB,
                            wdata: bus.BUS_WDATA};
                end else begin
                    lat = lat_q.pop_front();
                    cur = bus_q.pop_front();
                end
                active = 1'b1;
                cnt = 0;
            end
            if (active) begin
                chk("bus_req", bus.BUS_REQ, 32'd1);
                chk("bus_we", bus.BUS_WE, cur.we);
                chk("bus_addr", bus.BUS_ADDR, cur.addr);
                chk("bus_strb", bus.BUS_STRB, cur.strb);
                if (cur.we) chk("bus_wdata", bus.BUS_WDATA, cur.wdata);
                cnt++;
                if (cnt == lat) begin
                    bus.BUS_ACK = 1'b1;
                    w = bus.BUS_ADDR[31:2];
                    if (bus.BUS_WE) smem[w] = merge(sread(w), bus.BUS_WDATA, bus.BUS_STRB);
                    else            bus.BUS_RDATA = sread(w);
                    active = 1'b0;
                end else if (cnt == T) begin
                    active = 1'b0;
                end
            end
        end
    end

    task automatic idle();
        pipe.DATA_RDEN = 1'b0;
        pipe.DATA_WREN = 1'b0;
        @(posedge CLK); #1;
    endtask

    // Issue one pipeline request (called with MEM_WAIT low, at posedge+1)
    task automatic issue(input logic rd, input logic [31:0] raddr,
                         input logic wr, input logic [31:0] waddr,
                         input logic [3:0] strb, input logic [31:0] wdata,
                         input int unsigned lw, input int unsigned lr);
        int unsigned exp_cyc, cyc, w;
        logic        last_err;
        exp_cyc  = 0;
        last_err = 1'b0;
        if (wr) begin
            lat_q.push_back(lw);
            bus_q.push_back('{we: 1'b1, addr: {waddr[31:2], 2'b00}, strb: strb, wdata: wdata});
            exp_cyc += (lw < T) ? lw : T;
            if (lw <= T) begin
                w = waddr[31:2];
                mmem[w] = merge(mread(w), wdata, strb);
            end else begin
                err_exp++;
            end
            last_err = (lw > T);
        end
        if (rd) begin
            lat_q.push_back(lr);
            bus_q.push_back('{we: 1'b0, addr: {raddr[31:2], 2'b00}, strb: 4'hF, wdata: 32'h0});
            exp_cyc += (lr < T) ? lr : T;
            w = raddr[31:2];
            rd_q.push_back('{addr: raddr, data: (lr <= T) ? mread(w) : 32'h0, err: (lr > T)});
            if (lr > T) err_exp++;
            last_err = (lr > T);
            rv_exp++;
        end
        pipe.DATA_RDEN   = rd;
        pipe.DATA_RIADDR = raddr;
        pipe.DATA_WREN   = wr;
        pipe.DATA_WADDR  = waddr;
        pipe.DATA_WSTRB  = strb;
        pipe.DATA_WDATA  = wdata;
        cyc = 0;
        forever begin
            @(posedge CLK); #1;
            if (!pipe.MEM_WAIT) break;
            cyc++;
            if (cyc > 100) begin
                chk("mem_wait_bound", cyc, exp_cyc);
                report();
            end
        end
        chk("mem_wait_cycles", cyc, exp_cyc);
        chk("rvalid_at_release", pipe.DATA_RVALID, rd);
        chk("err_at_release", pipe.ERR, last_err);
    endtask

    function automatic int unsigned rand_lat();
        if ($urandom_range(0, 9) < 8) return $urandom_range(1, T);
        return $urandom_range(T + 1, T + 3);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    // Stimulus
    initial begin
        pipe.DATA_RDEN   = 1'b0;
        pipe.DATA_RIADDR = '0;
        pipe.DATA_WREN   = 1'b0;
        pipe.DATA_WADDR  = '0;
        pipe.DATA_WSTRB  = '0;
        pipe.DATA_WDATA  = '0;
        mmem[32'h401] = 32'hA1B2_C3D4;
        smem[32'h401] = 32'hA1B2_C3D4;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_mem_wait", pipe.MEM_WAIT, 32'd0);
        chk("rst_err", pipe.ERR, 32'd0);
        chk("rst_rvalid", pipe.DATA_RVALID, 32'd0);
        chk("rst_roaddr", pipe.DATA_ROADDR, 32'd0);
        chk("rst_rdata", pipe.DATA_RDATA, 32'd0);
        chk("rst_bus_req", bus.BUS_REQ, 32'd0);
        chk("rst_bus_we", bus.BUS_WE, 32'd0);
        chk("rst_bus_addr", bus.BUS_ADDR, 32'd0);
        chk("rst_bus_strb", bus.BUS_STRB, 32'd0);
        chk("rst_bus_wdata", bus.BUS_WDATA, 32'd0);
        RST = 1'b0;
        idle();

        issue(1'b1, 32'h1006, 1'b0, 32'h0, 4'h0, 32'h0, 0, 4);
        issue(1'b0, 32'h0, 1'b1, 32'h2003, 4'b1000, 32'hEF00_0000, 1, 0);
        issue(1'b1, 32'h3000, 1'b1, 32'h3000, 4'hF, 32'h1122_3344, 1, 1);
        issue(1'b1, 32'h1008, 1'b0, 32'h0, 4'h0, 32'h0, 0, NEVER);
        issue(1'b1, 32'h1006, 1'b0, 32'h0, 4'h0, 32'h0, 0, 2);
        issue(1'b1, 32'h10, 1'b0, 32'h0, 4'h0, 32'h0, 0, 1);
        issue(1'b1, 32'h14, 1'b0, 32'h0, 4'h0, 32'h0, 0, 1);
        issue(1'b1, 32'h2000, 1'b1, 32'h2000, 4'b0011, 32'h0000_BEEF, NEVER, 3);
        issue(1'b1, 32'h2002, 1'b0, 32'h0, 4'h0, 32'h0, 0, T);
        issue(1'b0, 32'h0, 1'b1, 32'h2001, 4'b0010, 32'h0000_AA00, T, 0);
        idle();

        for (int i = 0; i < 300; i++) begin
            int unsigned kind;
            logic [31:0] ra, wa;
            kind = $urandom_range(0, 9);
            ra = 32'h1000 + $urandom_range(0, 255);
            wa = ($urandom_range(0, 1) == 1) ? ra : 32'h1000 + $urandom_range(0, 255);
            if (kind == 0)
                idle();
            else if (kind <= 3)
                issue(1'b1, ra, 1'b0, 32'h0, 4'h0, 32'h0, 0, rand_lat());
            else if (kind <= 6)
                issue(1'b0, 32'h0, 1'b1, wa, 4'($urandom_range(0, 15)), $urandom, rand_lat(), 0);
            else
                issue(1'b1, ra, 1'b1, wa, 4'($urandom_range(0, 15)), $urandom,
                      rand_lat(), rand_lat());
        end
        idle();
        idle();

        // Reset in the middle of an outstanding read
        pipe.DATA_RDEN   = 1'b1;
        pipe.DATA_RIADDR = 32'h1100;
        lat_q.push_back(NEVER);
        bus_q.push_back('{we: 1'b0, addr: 32'h1100, strb: 4'hF, wdata: 32'h0});
        @(posedge CLK); #1;
        chk("rst_test_busy", pipe.MEM_WAIT, 32'd1);
        @(posedge CLK); #1;
        RST = 1'b1;
        pipe.DATA_RDEN = 1'b0;
        @(posedge CLK); #1;
        chk("midrst_mem_wait", pipe.MEM_WAIT, 32'd0);
        chk("midrst_bus_req", bus.BUS_REQ, 32'd0);
        chk("midrst_rdata", pipe.DATA_RDATA, 32'd0);
        chk("midrst_roaddr", pipe.DATA_ROADDR, 32'd0);
        chk("midrst_rvalid", pipe.DATA_RVALID, 32'd0);
        @(posedge CLK); #1;
        hold_addr = '0;
        hold_data = '0;
        RST = 1'b0;
        stale_ack = 1'b1;
        repeat (4) begin
            @(posedge CLK); #1;
            chk("stale_ack_rvalid", pipe.DATA_RVALID, 32'd0);
            chk("stale_ack_mem_wait", pipe.MEM_WAIT, 32'd0);
        end

        chk("err_pulse_count", err_seen, err_exp);
        chk("rvalid_count", rv_seen, rv_exp);
        chk("read_queue_left", rd_q.size(), 32'd0);
        chk("bus_queue_left", bus_q.size(), 32'd0);
        report();
    end

endmodule

// File: doc/data_port.md
Name: data_port

Overview:
- Data-side memory responder. Serves the pipeline's data read port (DATA_RDEN/DATA_RIADDR → DATA_RVALID/DATA_ROADDR/DATA_RDATA) and data write port (DATA_WREN/ADDR/STRB/DATA).
- Sequences both onto a single word-wide request/acknowledge memory bus with variable latency.
- Stalls the whole pipeline via MEM_WAIT while a transaction is outstanding.
- Sits between the pipeline memory stages and the memory/MMU bus.

Parameters:
- TIMEOUT, 255: max cycles waiting for BUS_ACK before the transaction is force-completed with error.
- TO_W, 8: width of the timeout counter; must satisfy TIMEOUT < 2^TO_W.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- MEM_WAIT  out  1  pipeline stall; high while a transaction is outstanding
- ERR  out  1  one-cycle pulse when a transaction times out
- DATA_RDEN  in  1  read request
- DATA_RIADDR  in  32  read byte address
- DATA_RVALID  out  1  one-cycle pulse: read data updated
- DATA_ROADDR  out  32  address of the last completed read
- DATA_RDATA  out  32  full word of the last completed read; held until the next read completes
- DATA_WREN  in  1  write request
- DATA_WADDR  in  32  write byte address
- DATA_WSTRB  in  4  byte enables, already lane-aligned
- DATA_WDATA  in  32  write data, already lane-aligned
- BUS_REQ  out  1  bus request; held until BUS_ACK
- BUS_WE  out  1  1 = write
- BUS_ADDR  out  32  word address, {addr[31:2], 2'b00}
- BUS_STRB  out  4  byte enables; 4'b1111 for reads
- BUS_WDATA  out  32  write data
- BUS_ACK  in  1  transaction complete (may be high in the first REQ cycle)
- BUS_RDATA  in  32  read data, valid with BUS_ACK

Behaviour:
- Reset (sync): state IDLE. All outputs 0: MEM_WAIT, ERR, DATA_RVALID, DATA_ROADDR, DATA_RDATA, BUS_*. Timeout counter 0, pending-read flag 0.
- All outputs are registered.
- FSM states: IDLE, WRITE, READ.
- Acceptance: only in IDLE, sampled at the clock edge.
  - Write and read together: write is issued first (it belongs to the older instruction); the read address is latched as pending.
  - IDLE→WRITE when DATA_WREN=1.
  - IDLE→READ when DATA_RDEN=1 and DATA_WREN=0.
  - On entry to WRITE or READ: BUS_* driven with the request and MEM_WAIT=1, both starting the next cycle.
- Requests presented in IDLE are always consumed by that edge. The pipeline holds its inputs while MEM_WAIT=1, so no request is lost or duplicated.
- WRITE with BUS_ACK=1:
  - If a read is pending: go to READ, reload BUS_* with the read, MEM_WAIT stays 1.
  - Otherwise: go to IDLE; BUS_REQ=0 and MEM_WAIT=0 next cycle.
- READ with BUS_ACK=1:
  - Latch DATA_RDATA=BUS_RDATA and DATA_ROADDR=original byte address (not word-aligned).
  - Pulse DATA_RVALID for 1 cycle.
  - Go to IDLE; MEM_WAIT=0 in the same cycle as the RVALID pulse.
- Minimum latency: request at edge t, BUS_REQ high at t+1.
  - ACK in cycle t+1 gives RVALID/MEM_WAIT=0 at t+2.
  - Read+write together: earliest completion is t+3.
- Bus payload stays stable while BUS_REQ=1 and BUS_ACK=0.
- Timeout:
  - Counter clears on every entry to WRITE or READ and increments each cycle without ACK.
  - On reaching TIMEOUT, the current op completes as if acknowledged. A read returns 0x00000000.
  - ERR pulses for 1 cycle; BUS_REQ drops next cycle.
  - A pending read still executes after a timed-out write.
- A late BUS_ACK arriving in IDLE is ignored.
- BUS_ACK in the same edge as timeout expiry: treated as a normal ACK, no ERR.
- RST mid-transaction: immediate return to IDLE, BUS_REQ=0, pending read discarded. The bus side must tolerate abandonment.
- DATA_RDATA/DATA_ROADDR do not change on writes.

Decomposition:
- Shared package (core constants, e.g. core_pkg):
  - state encoding DP_IDLE/DP_WRITE/DP_READ (2 bits)
  - STRB_WORD = 4'b1111
  - word-align mask
- One natural sub-module: dp_timeout. Counter with clear/enable inputs and an expire output. Reused later by the instruction-fetch port.

Test Plan:
- Single read: RDEN=1, RIADDR=0x1006, ACK after 3 cycles with RDATA=0xA1B2C3D4 → BUS_ADDR=0x1004, BUS_STRB=4'b1111, MEM_WAIT high 4 cycles, RVALID pulse, ROADDR=0x1006, RDATA=0xA1B2C3D4 held afterwards.
- Single write: WREN=1, WADDR=0x2003, WSTRB=4'b1000, WDATA=0xEF000000, ACK immediate → BUS_WE=1, BUS_ADDR=0x2000, 1 REQ cycle, MEM_WAIT=1 for 1 cycle, no RVALID.
- Simultaneous write (0x3000, data 0x11223344) and read (0x3000) with immediate ACK, memory model updating → write issued first, then read; RDATA=0x11223344; MEM_WAIT high 2 cycles.
- Timeout with TIMEOUT=4: read, never ACK → ERR pulse after 4 REQ cycles, RDATA=0, RVALID=1, MEM_WAIT drops; a later read with ACK succeeds normally.
- Reset mid-read: RST asserted during READ → next cycle MEM_WAIT=0, BUS_REQ=0, RDATA=0; a stale ACK afterwards produces no RVALID.
- Back-to-back reads 0x10 then 0x14 (second presented the cycle MEM_WAIT falls) → two RVALID pulses, ROADDR 0x10 then 0x14, no lost request.
